// File: rtl/aes_pkg.sv
// Shared AES types, InvMixColumns constants and small GF(2^8) helpers.
package aes_pkg;

  typedef logic [127:0] state_t;
  typedef logic [31:0]  col_t;
  typedef logic [7:0]   byte_t;

  localparam byte_t INV_MC_E = 8'h0E;
  localparam byte_t INV_MC_B = 8'h0B;
  localparam byte_t INV_MC_D = 8'h0D;
  localparam byte_t INV_MC_9 = 8'h09;
  localparam byte_t AES_POLY = 8'h1B;

  typedef enum logic [1:0] {
    IMC_IDLE = 2'd0,
    IMC_BUSY = 2'd1,
    IMC_DONE = 2'd2
  } imc_state_e;

  // Multiply by x (0x02) in GF(2^8), reducing modulo x^8+x^4+x^3+x+1.
  function automatic byte_t xtime(byte_t a);
    return {a[6:0], 1'b0} ^ (a[7] ? AES_POLY : 8'h00);
  endfunction

  // Coefficient of the InvMixColumns matrix: each row is the row above
  // rotated right by one, starting from {0e,0b,0d,09}.
  function automatic byte_t inv_mc_coef(int unsigned row, int unsigned col);
    case ((col + 4 - row) % 4)
      0:       return INV_MC_E;
      1:       return INV_MC_B;
      2:       return INV_MC_D;
      default: return INV_MC_9;
    endcase
  endfunction

  // LSB position of column idx inside a state: column 0 occupies [127:96].
  function automatic logic [6:0] col_lsb(logic [1:0] idx);
    return {~idx, 5'b0_0000};
  endfunction

endpackage

// File: rtl/gf_mul.sv
// Combinational GF(2^8) multiplier: sum of the shifted-and-reduced copies of a
// selected by the bits of b.
module gf_mul
  import aes_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] p
);

  byte_t pow_a [8];

  // Build a*x^i for i = 0..7, then accumulate the terms enabled by b.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' and give every output a
    // default before any conditional update, so no latch can be inferred.
    p        = '0;
    pow_a[0] = a;
    for (int i = 1; i < 8; i++) begin
      pow_a[i] = xtime(pow_a[i-1]);
    end
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ pow_a[i];
    end
  end

endmodule

// File: rtl/inv_mix_single_column.sv
// One InvMixColumns column: 4x4 constant matrix product over GF(2^8).
// Byte 0 (row 0) of the column sits in col_i[31:24].
module inv_mix_single_column
  import aes_pkg::*;
(
  input  logic [31:0] col_i,
  output logic [31:0] col_o
);

  byte_t s    [4];
  byte_t prod [4][4];

  for (genvar r = 0; r < 4; r++) begin : g_row
    assign s[r] = col_i[31-8*r -: 8];

    for (genvar c = 0; c < 4; c++) begin : g_col
      gf_mul u_mul (
        .a (s[c]),
        .b (inv_mc_coef(r, c)),
        .p (prod[r][c])
      );
    end

    assign col_o[31-8*r -: 8] = prod[r][0] ^ prod[r][1] ^ prod[r][2] ^ prod[r][3];
  end

endmodule

// File: rtl/inv_mix_columns_seq.sv
// Sequential AES InvMixColumns: captures a 128-bit state, transforms
// COLS_PER_CYCLE columns per cycle in place, then holds the result until the
// downstream stage takes it. A retiring result and a new capture may share a cycle.
module inv_mix_columns_seq
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_param_check
    $fatal(1, "inv_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] COL_LAST = 2'(4 - COLS_PER_CYCLE);

  imc_state_e fsm_q,       fsm_d;
  logic [1:0] col_cnt_q,   col_cnt_d;
  state_t     state_reg_q, state_reg_d;
  logic       out_valid_q, out_valid_d;
  logic       busy_q,      busy_d;
  logic       take;

  col_t col_in  [COLS_PER_CYCLE];
  col_t col_out [COLS_PER_CYCLE];

  // Column datapath: pick the columns addressed by col_cnt and transform them.
  for (genvar i = 0; i < COLS_PER_CYCLE; i++) begin : g_col
    logic [1:0] col_idx;
    assign col_idx   = col_cnt_q + 2'(i);
    assign col_in[i] = state_reg_q[col_lsb(col_idx) +: 32];

    inv_mix_single_column u_col (
      .col_i (col_in[i]),
      .col_o (col_out[i])
    );
  end

  // Ready while idle, or while the held result is being retired this cycle.
  assign in_ready = (fsm_q == IMC_IDLE) || ((fsm_q == IMC_DONE) && out_ready);
  assign take     = in_valid && in_ready;

  // Next-state logic: capture, column-by-column write-back, and hand-off.
  always_comb begin
    fsm_d       = fsm_q;
    col_cnt_d   = col_cnt_q;
    state_reg_d = state_reg_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;

    case (fsm_q)
      IMC_IDLE: begin
        if (take) begin
          fsm_d       = IMC_BUSY;
          state_reg_d = in_state;
          col_cnt_d   = '0;
          busy_d      = 1'b1;
        end
      end

      IMC_BUSY: begin
        for (int i = 0; i < COLS_PER_CYCLE; i++) begin
          state_reg_d[col_lsb(col_cnt_q + 2'(i)) +: 32] = col_out[i];
        end
        if (col_cnt_q == COL_LAST) begin
          fsm_d       = IMC_DONE;
          col_cnt_d   = '0;
          out_valid_d = 1'b1;
          busy_d      = 1'b0;
        end else begin
          col_cnt_d = col_cnt_q + COL_STEP;
        end
      end

      IMC_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (in_valid) begin
            fsm_d       = IMC_BUSY;
            state_reg_d = in_state;
            col_cnt_d   = '0;
            busy_d      = 1'b1;
          end else begin
            fsm_d = IMC_IDLE;
          end
        end
      end

      default: begin
        fsm_d       = IMC_IDLE;
        col_cnt_d   = '0;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  // State registers; reset clears any partial or pending result at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= IMC_IDLE;
      col_cnt_q   <= '0;
      // NOTE: the data register is reset too, because out_state must read
      // zero after reset rather than leak the previous result.
      state_reg_q <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      // NOTE: clocked state uses non-blocking '<=' so every flop samples
      // the values computed before this edge.
      fsm_q       <= fsm_d;
      col_cnt_q   <= col_cnt_d;
      state_reg_q <= state_reg_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign out_state = state_reg_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Bench for inv_mix_columns_seq: three instances (1, 2 and 4 columns per
// cycle) checked against a matrix-level GF(2^8) reference model.
module tb_inv_mix_columns_seq;

  logic         clk;
  logic         rst_n;
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic [127:0] in_state  [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic [127:0] out_state [3];
  logic         busy      [3];

  int unsigned n_cmp;
  int unsigned n_bad;

  inv_mix_columns_seq #(.COLS_PER_CYCLE(1)) u_c1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_state(in_state[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_state(out_state[0]), .busy(busy[0]));

  inv_mix_columns_seq #(.COLS_PER_CYCLE(2)) u_c2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_state(in_state[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_state(out_state[1]), .busy(busy[1]));

  inv_mix_columns_seq #(.COLS_PER_CYCLE(4)) u_c4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_state(in_state[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_state(out_state[2]), .busy(busy[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int n_cyc(int k);
    return (k == 0) ? 4 : (k == 1) ? 2 : 1;
  endfunction

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00; x = a; y = b;
    while (y != 0) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] mat_apply(logic [127:0] s, logic [7:0] r0 [4]);
    logic [7:0]   b [16];
    logic [7:0]   acc;
    logic [127:0] res;
    for (int k = 0; k < 16; k++) b[k] = s[127-8*k -: 8];
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc = acc ^ gmul(r0[(j - r + 4) % 4], b[4*c + j]);
        res[127-8*(4*c + r) -: 8] = acc;
      end
    end
    return res;
  endfunction

  function automatic logic [127:0] inv_mc(logic [127:0] s);
    logic [7:0] r0 [4];
    r0 = '{8'h0E, 8'h0B, 8'h0D, 8'h09};
    return mat_apply(s, r0);
  endfunction

  function automatic logic [127:0] mix_c(logic [127:0] s);
    logic [7:0] r0 [4];
    r0 = '{8'h02, 8'h03, 8'h01, 8'h01};
    return mat_apply(s, r0);
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- drivers (called and returning at a falling edge) ----------------
  task automatic send(input int k, input logic [127:0] st);
    int n;
    in_valid[k] = 1'b1;
    in_state[k] = st;
    n = 0;
    while (!in_ready[k] && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready[k]) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout dut%0d: in_ready=%0b required 1", k, in_ready[k]);
    end
    @(negedge clk);
    in_valid[k] = 1'b0;
  endtask

  task automatic wait_valid(input int k, output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = 0;
    while (!out_valid[k] && lat < 40) begin
      if (busy[k]) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    if (!out_valid[k]) begin
      n_cmp++; n_bad++;
      $display("FAIL out_valid_timeout dut%0d: out_valid=%0b required 1", k, out_valid[k]);
    end
  endtask

  task automatic accept(input int k);
    out_ready[k] = 1'b1;
    @(negedge clk);
    out_ready[k] = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      n_cmp += 4;
      if (in_ready[k] !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready dut%0d: got %b want 1", k, in_ready[k]); end
      if (out_valid[k] !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid dut%0d: got %b want 0", k, out_valid[k]); end
      if (busy[k] !== 1'b0) begin n_bad++; $display("FAIL reset_busy dut%0d: got %b want 0", k, busy[k]); end
      if (out_state[k] !== 128'h0) begin n_bad++; $display("FAIL reset_out_state dut%0d: got %h want 0", k, out_state[k]); end
    end
  endtask

  task automatic test_single_column();
    int lat, bc;
    logic [127:0] exp_s;
    exp_s = {32'hdb135345, 96'h0};
    send(0, {32'h8e4da1bc, 96'h0});
    wait_valid(0, lat, bc);
    n_cmp += 3;
    if (lat + 1 != 5) begin n_bad++; $display("FAIL single_latency: got %0d want 5", lat + 1); end
    if (bc != 4) begin n_bad++; $display("FAIL single_busy_cycles: got %0d want 4", bc); end
    if (out_state[0] !== exp_s) begin n_bad++; $display("FAIL single_out: got %h want %h", out_state[0], exp_s); end
    accept(0);
  endtask

  task automatic test_known_vectors();
    int lat, bc;
    logic [127:0] vin, vexp;
    vin  = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
    vexp = 128'hdb135345_f20a225c_01010101_d4d4d4d5;
    for (int k = 0; k < 3; k++) begin
      send(k, vin);
      wait_valid(k, lat, bc);
      n_cmp += 2;
      if (lat + 1 != n_cyc(k) + 1) begin n_bad++; $display("FAIL vec_latency dut%0d: got %0d want %0d", k, lat + 1, n_cyc(k) + 1); end
      if (out_state[k] !== vexp) begin n_bad++; $display("FAIL vec_out dut%0d: got %h want %h", k, out_state[k], vexp); end
      accept(k);
      n_cmp++;
      if (out_valid[k] !== 1'b0) begin n_bad++; $display("FAIL vec_retire dut%0d: out_valid got %b want 0", k, out_valid[k]); end
    end
  endtask

  task automatic test_backpressure();
    int lat, bc;
    int bad_cycles;
    logic [127:0] st, exp_s;
    st = rand128();
    exp_s = inv_mc(st);
    send(0, st);
    wait_valid(0, lat, bc);
    bad_cycles = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid[0] !== 1'b1 || out_state[0] !== exp_s || in_ready[0] !== 1'b0) bad_cycles++;
      @(negedge clk);
    end
    n_cmp++;
    if (bad_cycles != 0) begin n_bad++; $display("FAIL bp_stable: unstable cycles got %0d want 0", bad_cycles); end
    accept(0);
    bad_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      if (out_valid[0] !== 1'b0) bad_cycles++;
      @(negedge clk);
    end
    n_cmp++;
    if (bad_cycles != 0) begin n_bad++; $display("FAIL bp_single_transfer: extra valid cycles got %0d want 0", bad_cycles); end
  endtask

  task automatic test_back_to_back(input int k);
    localparam int M = 6;
    logic [127:0] q [M];
    int sent, got, last, cyc, budget;
    logic fire;
    for (int i = 0; i < M; i++) q[i] = rand128();
    sent = 0; got = 0; last = 0; cyc = 0;
    budget = M * (n_cyc(k) + 1) + 20;
    in_state[k] = q[0];
    in_valid[k] = 1'b1;
    out_ready[k] = 1'b1;
    while (got < M && cyc < budget) begin
      if (out_valid[k]) begin
        n_cmp++;
        if (out_state[k] !== inv_mc(q[got])) begin
          n_bad++; $display("FAIL b2b_out dut%0d #%0d: got %h want %h", k, got, out_state[k], inv_mc(q[got]));
        end
        if (got > 0) begin
          n_cmp++;
          if (cyc - last != n_cyc(k) + 1) begin
            n_bad++; $display("FAIL b2b_spacing dut%0d: got %0d want %0d", k, cyc - last, n_cyc(k) + 1);
          end
        end
        last = cyc;
        got++;
      end
      fire = in_valid[k] && in_ready[k];
      @(posedge clk);
      #1;
      if (fire) begin
        sent++;
        if (sent < M) in_state[k] = q[sent];
        else in_valid[k] = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid[k] = 1'b0;
    out_ready[k] = 1'b0;
    n_cmp++;
    if (got != M) begin n_bad++; $display("FAIL b2b_count dut%0d: got %0d want %0d", k, got, M); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_busy();
    int lat, bc, bad_cycles;
    logic [127:0] st;
    send(0, rand128());
    @(posedge clk);
    #2;
    n_cmp++;
    if (busy[0] !== 1'b1) begin n_bad++; $display("FAIL rst_pre_busy: got %b want 1", busy[0]); end
    rst_n = 1'b0;
    #1;
    n_cmp += 4;
    if (out_valid[0] !== 1'b0) begin n_bad++; $display("FAIL rst_async_out_valid: got %b want 0", out_valid[0]); end
    if (in_ready[0] !== 1'b1) begin n_bad++; $display("FAIL rst_async_in_ready: got %b want 1", in_ready[0]); end
    if (busy[0] !== 1'b0) begin n_bad++; $display("FAIL rst_async_busy: got %b want 0", busy[0]); end
    if (out_state[0] !== 128'h0) begin n_bad++; $display("FAIL rst_async_out_state: got %h want 0", out_state[0]); end
    @(negedge clk);
    rst_n = 1'b1;
    bad_cycles = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid[0] !== 1'b0 || busy[0] !== 1'b0) bad_cycles++;
      @(negedge clk);
    end
    n_cmp++;
    if (bad_cycles != 0) begin n_bad++; $display("FAIL rst_no_residue: active cycles got %0d want 0", bad_cycles); end
    st = rand128();
    send(0, st);
    wait_valid(0, lat, bc);
    n_cmp++;
    if (out_state[0] !== inv_mc(st)) begin n_bad++; $display("FAIL rst_after_out: got %h want %h", out_state[0], inv_mc(st)); end
    accept(0);
  endtask

  task automatic test_random();
    int lat, bc, k;
    logic [127:0] x, st, exp_s;
    for (int i = 0; i < 1000; i++) begin
      k = i % 3;
      x = rand128();
      if ((i % 4) == 3) begin
        st = mix_c(x);
        exp_s = x;
      end else begin
        st = x;
        exp_s = inv_mc(x);
      end
      send(k, st);
      wait_valid(k, lat, bc);
      n_cmp++;
      if (out_state[k] !== exp_s) begin
        n_bad++; $display("FAIL random dut%0d #%0d: in %h got %h want %h", k, i, st, out_state[k], exp_s);
      end
      accept(k);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid[k]  = 1'b0;
      in_state[k]  = '0;
      out_ready[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_single_column();
    test_known_vectors();
    test_backpressure();
    for (int k = 0; k < 3; k++) test_back_to_back(k);
    test_reset_mid_busy();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
